// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU op codes, legal-code check and arbiter FSM state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic is_legal(input logic [3:0] code);
        return (code == ALU_AND) || (code == ALU_OR) || (code == ALU_ADD) ||
               (code == ALU_SUB) || (code == ALU_SLT);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way grant select; round-robin by default, fixed priority
// to requester 0 when ALU_ARB_FIXED_PRIO_EN is defined.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic       gnt_id
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign gnt_id = ~req[0];
`else
    logic last_id;

    // last_id resets to 1 so requester 0 wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_id <= 1'b1;
        else if (take)
            last_id <= gnt_id;
    end

    always_comb begin
        gnt_id = ~req[0];
        if (req == 2'b11)
            gnt_id = ~last_id;
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one combinational ALU between two requesters with
// registered operands and tagged responses; ALU_ARB_FIXED_PRIO_EN selects fixed priority.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DW = 32,
    parameter int CW = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req0_valid_i,
    output logic          req0_ready_o,
    input  logic [CW-1:0] req0_ctrl_i,
    input  logic [DW-1:0] req0_src1_i,
    input  logic [DW-1:0] req0_src2_i,
    input  logic          req1_valid_i,
    output logic          req1_ready_o,
    input  logic [CW-1:0] req1_ctrl_i,
    input  logic [DW-1:0] req1_src1_i,
    input  logic [DW-1:0] req1_src2_i,
    output logic [DW-1:0] alu_src1_o,
    output logic [DW-1:0] alu_src2_o,
    output logic [CW-1:0] alu_ctrl_o,
    input  logic [DW-1:0] alu_result_i,
    input  logic          alu_zero_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic          rsp_id_o,
    output logic [DW-1:0] rsp_result_o,
    output logic          rsp_zero_o,
    output logic          rsp_err_o,
    output logic          busy_o
);

    state_t        state, state_nxt;
    logic [CW-1:0] op_ctrl;
    logic [DW-1:0] op_src1, op_src2;
    logic          op_id;
    logic          op_legal;
    logic          grant_win, grant_en, gnt_id;

    rr_arb2 u_arb (
        .clk    (clk_i),
        .rst    (rst_i),
        .req    ({req1_valid_i, req0_valid_i}),
        .take   (grant_en),
        .gnt_id (gnt_id)
    );

    assign op_legal = is_legal(4'(op_ctrl));

    always_comb begin
        state_nxt = state;
        grant_win = (state == ST_IDLE) || ((state == ST_RESP) && rsp_ready_i);
        grant_en  = grant_win && (req0_valid_i || req1_valid_i);
        case (state)
            ST_IDLE: if (grant_en) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready_i) state_nxt = grant_en ? ST_EXEC : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign req0_ready_o = grant_en && !gnt_id;
    assign req1_ready_o = grant_en &&  gnt_id;

    // Outside EXEC, and for illegal codes, the ALU sees a harmless ADD
    assign alu_ctrl_o  = ((state == ST_EXEC) && op_legal) ? op_ctrl : CW'(ALU_ADD);
    assign alu_src1_o  = op_src1;
    assign alu_src2_o  = op_src2;
    assign rsp_valid_o = (state == ST_RESP);
    assign busy_o      = (state != ST_IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_ctrl <= '0;
            op_src1 <= '0;
            op_src2 <= '0;
            op_id   <= 1'b0;
        end else if (grant_en) begin
            op_ctrl <= gnt_id ? req1_ctrl_i : req0_ctrl_i;
            op_src1 <= gnt_id ? req1_src1_i : req0_src1_i;
            op_src2 <= gnt_id ? req1_src2_i : req0_src2_i;
            op_id   <= gnt_id;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_result_o <= '0;
            rsp_zero_o   <= 1'b0;
            rsp_err_o    <= 1'b0;
            rsp_id_o     <= 1'b0;
        end else if (state == ST_EXEC) begin
            rsp_result_o <= op_legal ? alu_result_i : '0;
            rsp_zero_o   <= op_legal ? alu_zero_i : 1'b1;
            rsp_err_o    <= !op_legal;
            rsp_id_o     <= op_id;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter with a behavioural ALU.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_ctrl = '0, req1_ctrl = '0;
    logic [31:0] req0_src1 = '0, req0_src2 = '0, req1_src1 = '0, req1_src2 = '0;
    logic [31:0] alu_src1, alu_src2, alu_result;
    logic [3:0]  alu_ctrl;
    logic        alu_zero;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_zero, rsp_err, busy;
    logic [31:0] rsp_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            ALU_ADD: alu_result = alu_src1 + alu_src2;
            ALU_SUB: alu_result = alu_src1 - alu_src2;
            ALU_AND: alu_result = alu_src1 & alu_src2;
            ALU_OR:  alu_result = alu_src1 | alu_src2;
            ALU_SLT: alu_result = {31'b0, $signed(alu_src1) < $signed(alu_src2)};
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    alu_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_ctrl_i(req0_ctrl),
        .req0_src1_i(req0_src1), .req0_src2_i(req0_src2),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_ctrl_i(req1_ctrl),
        .req1_src1_i(req1_src1), .req1_src2_i(req1_src2),
        .alu_src1_o(alu_src1), .alu_src2_o(alu_src2), .alu_ctrl_o(alu_ctrl),
        .alu_result_i(alu_result), .alu_zero_i(alu_zero),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
        .rsp_result_o(rsp_result), .rsp_zero_o(rsp_zero), .rsp_err_o(rsp_err),
        .busy_o(busy)
    );

    typedef struct {
        logic        id;
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        err;
        logic [3:0]  actl;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic drive(input logic id, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        if (id) begin
            req1_valid = 1'b1; req1_ctrl = c; req1_src1 = a; req1_src2 = b;
        end else begin
            req0_valid = 1'b1; req0_ctrl = c; req0_src1 = a; req0_src2 = b;
        end
    endtask

    task automatic do_op(input vec_t v);
        logic got;
        got = 1'b0;
        drive(v.id, v.ctrl, v.a, v.b);
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            got = v.id ? req1_ready : req0_ready;
            if (!got) step();
        end
        chk("grant", {31'b0, got}, 32'd1);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("exec_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("exec_alu_ctrl", {28'b0, alu_ctrl}, {28'b0, v.actl});
        chk("exec_alu_src1", alu_src1, v.a);
        step();
        @(negedge clk);
        chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("rsp_id", {31'b0, rsp_id}, {31'b0, v.id});
        chk("rsp_result", rsp_result, v.res);
        chk("rsp_zero", {31'b0, rsp_zero}, {31'b0, v.zero});
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, v.err});
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b0, ALU_ADD, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0, ALU_ADD};
        vecs[1] = '{1'b1, ALU_SUB, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1'b0, ALU_SUB};
        vecs[2] = '{1'b0, ALU_AND, 32'h0000F0F0, 32'h00000FF0, 32'h000000F0, 1'b0, 1'b0, ALU_AND};
        vecs[3] = '{1'b1, ALU_OR,  32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b0, 1'b0, ALU_OR};
        vecs[4] = '{1'b0, ALU_SLT, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0, ALU_SLT};
        vecs[5] = '{1'b0, ALU_SLT, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b1, 1'b0, ALU_SLT};
        vecs[6] = '{1'b1, ALU_SUB, 32'd9,        32'd9,        32'd0,        1'b1, 1'b0, ALU_SUB};
        vecs[7] = '{1'b1, 4'b1111, 32'd100,      32'd23,       32'd0,        1'b1, 1'b1, ALU_ADD};
        vecs[8] = '{1'b0, ALU_ADD, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0, ALU_ADD};

        do_reset();
        @(negedge clk);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_alu_ctrl", {28'b0, alu_ctrl}, {28'b0, ALU_ADD});
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_ready0", {31'b0, req0_ready}, 32'd0);
        step();

        for (int i = 0; i < 9; i++) do_op(vecs[i]);

        // Tie after reset: req0 first, then req1, then req0 again
        do_reset();
        drive(1'b0, ALU_SUB, 32'd9, 32'd9);
        drive(1'b1, ALU_SLT, 32'hFFFFFFFF, 32'd1);
        @(negedge clk);
        chk("tie_ready0", {31'b0, req0_ready}, 32'd1);
        chk("tie_ready1", {31'b0, req1_ready}, 32'd0);
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("tie_exec_ready1", {31'b0, req1_ready}, 32'd0);
        step();
        @(negedge clk);
        chk("tie_rsp_id0", {31'b0, rsp_id}, 32'd0);
        chk("tie_rsp_res0", rsp_result, 32'd0);
        chk("tie_rsp_zero0", {31'b0, rsp_zero}, 32'd1);
        rsp_ready = 1'b1;
        #1;
        chk("b2b_ready1", {31'b0, req1_ready}, 32'd1);
        step();
        rsp_ready = 1'b0;
        req1_valid = 1'b0;
        step();
        @(negedge clk);
        chk("tie_rsp_id1", {31'b0, rsp_id}, 32'd1);
        chk("tie_rsp_res1", rsp_result, 32'd1);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rsp_ready = 1'b1;
        #1;
        chk("tie2_ready0", {31'b0, req0_ready}, 32'd1);
        chk("tie2_ready1", {31'b0, req1_ready}, 32'd0);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b0;
        step();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Consumer stalls the response with req1 waiting
        drive(1'b0, ALU_ADD, 32'd20, 32'd22);
        @(negedge clk);
        chk("stall_grant0", {31'b0, req0_ready}, 32'd1);
        step();
        req0_valid = 1'b0;
        drive(1'b1, ALU_OR, 32'd3, 32'd4);
        @(negedge clk);
        chk("stall_exec_ready1", {31'b0, req1_ready}, 32'd0);
        step();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("stall_rsp_result", rsp_result, 32'd42);
            chk("stall_rsp_id", {31'b0, rsp_id}, 32'd0);
            chk("stall_ready0", {31'b0, req0_ready}, 32'd0);
            chk("stall_ready1", {31'b0, req1_ready}, 32'd0);
            chk("stall_busy", {31'b0, busy}, 32'd1);
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_ready1", {31'b0, req1_ready}, 32'd1);
        step();
        rsp_ready = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("stall_exec_valid", {31'b0, rsp_valid}, 32'd0);
        chk("stall_exec_busy", {31'b0, busy}, 32'd1);
        step();
        @(negedge clk);
        chk("stall_rsp2_id", {31'b0, rsp_id}, 32'd1);
        chk("stall_rsp2_result", rsp_result, 32'd7);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Asynchronous reset while an op is in EXEC
        drive(1'b0, ALU_ADD, 32'd1, 32'd2);
        @(negedge clk);
        step();
        req0_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("arst_alu_ctrl", {28'b0, alu_ctrl}, {28'b0, ALU_ADD});
        chk("arst_alu_src1", alu_src1, 32'd0);
        chk("arst_alu_src2", alu_src2, 32'd0);
        chk("arst_rsp_result", rsp_result, 32'd0);
        chk("arst_rsp_id", {31'b0, rsp_id}, 32'd0);
        chk("arst_rsp_zero", {31'b0, rsp_zero}, 32'd0);
        chk("arst_rsp_err", {31'b0, rsp_err}, 32'd0);
        step();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("arst_no_rsp", {31'b0, rsp_valid}, 32'd0);
            step();
        end
        do_op(vecs[0]);

        // Both requesters valid continuously with the consumer always ready
        do_reset();
        drive(1'b0, ALU_ADD, 32'd1, 32'd1);
        drive(1'b1, ALU_ADD, 32'd2, 32'd2);
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("cont_one_grant", {31'b0, req0_ready ^ req1_ready}, 32'd1);
`ifdef ALU_ARB_FIXED_PRIO_EN
            chk("cont_grant_id", {31'b0, req1_ready}, 32'd0);
`else
            chk("cont_grant_id", {31'b0, req1_ready}, i % 2);
`endif
            step();
            step();
        end
        req0_valid = 1'b0;
        @(negedge clk);
        chk("cont_req1_after_drop", {31'b0, req1_ready}, 32'd1);
        step();
        req1_valid = 1'b0;
        step();
        step();
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("cont_idle", {31'b0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
